// File: rtl/cache_pkg.sv
// Shared widths and types for the set-associative word cache and its ways.
package cache_pkg;

  localparam int WORD_W = 16;

  function automatic int tag_w(input int addr_w, input int set_bits);
    return addr_w - 2 - set_bits;
  endfunction

  function automatic int set_w(input int set_bits);
    return set_bits;
  endfunction

  function automatic int line_w();
    return 4 * WORD_W;
  endfunction

  localparam int LINE_W = line_w();

  typedef enum logic [1:0] {
    WORD0 = 2'd0,
    WORD1 = 2'd1,
    WORD2 = 2'd2,
    WORD3 = 2'd3
  } word_sel_e;

  // Associativity is at most 2, so a single bit names a way.
  typedef logic way_idx_t;

endpackage

// File: rtl/cache_assoc_if.sv
// Lookup, fill, snoop and statistics signals between the bus side and the cache.
interface cache_assoc_if #(
  parameter int ADDR_W = 23,
  parameter int CNT_W  = 16
);
  logic              flush;
  logic              strobe;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        ds;
  logic [15:0]       dout;
  logic              hit;
  logic [63:0]       din64;
  logic              store;
  logic [15:0]       din16;
  logic              update;
  logic              stat_clr;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;

  modport master (
    output flush, strobe, addr, ds, din64, store, din16, update, stat_clr,
    input  dout, hit, hit_count, miss_count
  );

  modport slave (
    input  flush, strobe, addr, ds, din64, store, din16, update, stat_clr,
    output dout, hit, hit_count, miss_count
  );
endinterface

// File: rtl/cache_way.sv
// One cache way: tag RAM, eight byte-lane data RAMs and a valid vector, with a
// registered read port and a combinational probe of the write set for victim/snoop decisions.
module cache_way
  import cache_pkg::*;
#(
  parameter int TAG_W = 14,
  parameter int SET_W = 7
) (
  input  logic              clk_128,
  input  logic              reset_n,
  input  logic              flush,
  input  logic [SET_W-1:0]  rd_set,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_data,
  input  logic [SET_W-1:0]  wr_set,
  input  logic [TAG_W-1:0]  wr_tag,
  output logic              pr_valid,
  output logic              pr_match,
  input  logic              tag_we,
  input  logic [7:0]        wr_be,
  input  logic [LINE_W-1:0] wr_data
);
  localparam int SETS = 1 << SET_W;

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tag_ram [SETS];

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk_128) begin
    if (!reset_n || flush) valid <= '0;
    else if (tag_we)       valid[wr_set] <= 1'b1;
  end

  // NOTE: tag and data RAMs are deliberately not reset; valid alone qualifies their contents.
  always_ff @(posedge clk_128) begin
    if (tag_we) tag_ram[wr_set] <= wr_tag;
    rd_tag   <= tag_ram[rd_set];
    rd_valid <= valid[rd_set];
  end

  for (genvar b = 0; b < 8; b++) begin : g_lane
    logic [7:0] lane_ram [SETS];

    always_ff @(posedge clk_128) begin
      if (wr_be[b]) lane_ram[wr_set] <= wr_data[8*b +: 8];
      rd_data[8*b +: 8] <= lane_ram[rd_set];
    end
  end

  assign pr_valid = valid[wr_set];
  assign pr_match = valid[wr_set] && (tag_ram[wr_set] == wr_tag);

endmodule

// File: rtl/cache_assoc.sv
// Set-associative word cache: 2-cycle lookup pipeline, true-LRU fills, snooped
// byte writes, write-hazard squash and saturating hit/miss statistics.
module cache_assoc
  import cache_pkg::*;
#(
  parameter int ADDR_W   = 23,
  parameter int SET_BITS = 7,
  parameter int WAYS     = 2,
  parameter int CNT_W    = 16
) (
  input logic          clk_128,
  input logic          reset_n,
  cache_assoc_if.slave bus
);
  localparam int TAG_W = tag_w(ADDR_W, SET_BITS);
  localparam int SET_W = set_w(SET_BITS);
  localparam int SETS  = 1 << SET_W;

  logic [TAG_W-1:0] cur_tag;
  logic [SET_W-1:0] cur_set;
  assign cur_tag = bus.addr[ADDR_W-1 -: TAG_W];
  assign cur_set = bus.addr[2 +: SET_W];

  // Write priority: flush drops a concurrent store, store drops a concurrent update.
  logic do_store, do_update, wr_any;
  assign do_store  = bus.store && !bus.flush;
  assign do_update = bus.update && !bus.store && !bus.flush;
  assign wr_any    = bus.store || bus.update || bus.flush;

  logic [WAYS-1:0]   pr_valid, pr_match, rd_valid, tag_we;
  logic [TAG_W-1:0]  rd_tag  [WAYS];
  logic [LINE_W-1:0] rd_data [WAYS];
  logic [7:0]        wr_be   [WAYS];
  logic [LINE_W-1:0] wr_data;
  logic [7:0]        upd_be;
  logic [SETS-1:0]   lru;
  way_idx_t          victim;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    victim = '0;
    if (WAYS > 1) begin
      victim = lru[cur_set];
      for (int w = WAYS - 1; w >= 0; w--) if (!pr_valid[w]) victim = way_idx_t'(w);
      for (int w = 0; w < WAYS; w++)      if (pr_match[w])  victim = way_idx_t'(w);
    end
  end

  // ds[0] gates the upper byte, ds[1] the lower byte of the addressed word.
  always_comb begin
    upd_be = '0;
    for (int k = 0; k < 4; k++)
      if (bus.addr[1:0] == 2'(k)) upd_be[2*k +: 2] = {bus.ds[0], bus.ds[1]};
  end

  assign wr_data = do_store ? bus.din64 : {4{bus.din16}};

  // Pipeline: s0 holds the sampled request, s1 travels alongside the registered array read.
  logic             s0_v, s0_sq, s1_v, s1_sq;
  logic [TAG_W-1:0] s0_tag, s1_tag;
  logic [SET_W-1:0] s0_set, s1_set;
  word_sel_e        s0_word, s1_word;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    assign tag_we[g] = do_store && (victim == way_idx_t'(g));
    assign wr_be[g]  = do_store ? {8{victim == way_idx_t'(g)}}
                     : (do_update && pr_match[g]) ? upd_be : 8'h00;

    cache_way #(.TAG_W(TAG_W), .SET_W(SET_W)) u_way (
      .clk_128 (clk_128),
      .reset_n (reset_n),
      .flush   (bus.flush),
      .rd_set  (s0_set),
      .rd_valid(rd_valid[g]),
      .rd_tag  (rd_tag[g]),
      .rd_data (rd_data[g]),
      .wr_set  (cur_set),
      .wr_tag  (cur_tag),
      .pr_valid(pr_valid[g]),
      .pr_match(pr_match[g]),
      .tag_we  (tag_we[g]),
      .wr_be   (wr_be[g]),
      .wr_data (wr_data)
    );
  end

  logic              look_hit, resolved;
  way_idx_t          hit_way;
  logic [LINE_W-1:0] hit_line;
  logic [15:0]       hit_word;

  always_comb begin
    look_hit = 1'b0;
    hit_way  = '0;
    hit_line = '0;
    for (int w = 0; w < WAYS; w++)
      if (rd_valid[w] && rd_tag[w] == s1_tag) begin
        look_hit = 1'b1;
        hit_way  = way_idx_t'(w);
        hit_line = rd_data[w];
      end
    case (s1_word)
      WORD0:   hit_word = hit_line[15:0];
      WORD1:   hit_word = hit_line[31:16];
      WORD2:   hit_word = hit_line[47:32];
      default: hit_word = hit_line[63:48];
    endcase
  end

  assign resolved = s1_v && !s1_sq;

  logic             hit_q;
  logic [15:0]      dout_q;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;

  always_ff @(posedge clk_128) begin
    if (!reset_n) begin
      s0_v   <= 1'b0;
      s0_sq  <= 1'b0;
      s1_v   <= 1'b0;
      s1_sq  <= 1'b0;
      hit_q  <= 1'b0;
      dout_q <= '0;
    end else begin
      s0_v   <= bus.strobe;
      s0_sq  <= wr_any;
      s1_v   <= s0_v;
      s1_sq  <= s0_sq || wr_any;
      hit_q  <= resolved && look_hit;
      dout_q <= (resolved && look_hit) ? hit_word : 16'h0000;
    end
  end

  always_ff @(posedge clk_128) begin
    s0_tag  <= cur_tag;
    s0_set  <= cur_set;
    s0_word <= word_sel_e'(bus.addr[1:0]);
    s1_tag  <= s0_tag;
    s1_set  <= s0_set;
    s1_word <= s0_word;
  end

  // A store to the same set as a resolving hit is written last so its LRU choice wins.
  always_ff @(posedge clk_128) begin
    if (!reset_n || bus.flush) lru <= '0;
    else begin
      if (resolved && look_hit) lru[s1_set]  <= ~hit_way;
      if (do_store)             lru[cur_set] <= ~victim;
    end
  end

  always_ff @(posedge clk_128) begin
    if (!reset_n || bus.stat_clr) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (resolved) begin
      if (look_hit) begin
        if (!(&hit_cnt)) hit_cnt <= hit_cnt + 1'b1;
      end else if (!(&miss_cnt)) begin
        miss_cnt <= miss_cnt + 1'b1;
      end
    end
  end

  assign bus.hit        = hit_q;
  assign bus.dout       = dout_q;
  assign bus.hit_count  = hit_cnt;
  assign bus.miss_count = miss_cnt;

endmodule
